// File: rtl/regfile_operand_fetch.sv
// Operand fetch: drives register file reads, tracks pending writes,
// stalls on read-after-write hazards and bypasses same-cycle writeback.
module regfile_operand_fetch #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_src_a,
  input  logic [AW-1:0]    in_src_b,
  input  logic [AW-1:0]    in_dst,
  input  logic             in_dst_en,
  output logic [AW-1:0]    rf_a_address,
  output logic [AW-1:0]    rf_b_address,
  input  logic [WIDTH-1:0] rf_a_data,
  input  logic [WIDTH-1:0] rf_b_data,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_address,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [AW-1:0]    out_dst,
  output logic             out_dst_en,
  output logic [7:0]       stall_cnt
);

  localparam int NREG = 1 << AW;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  state_t            state;
  logic [AW-1:0]     src_a_q;
  logic [AW-1:0]     src_b_q;
  logic [AW-1:0]     dst_q;
  logic              dst_en_q;
  logic [NREG-1:0]   scoreboard;
  logic              in_ready_q;

  logic              wb_hit_a;
  logic              wb_hit_b;
  logic              haz_a;
  logic              haz_b;
  logic              hazard;
  logic              fetch_done;
  logic [WIDTH-1:0]  opnd_a;
  logic [WIDTH-1:0]  opnd_b;
  logic [NREG-1:0]   sb_clr;
  logic [NREG-1:0]   sb_set;
  logic [NREG-1:0]   sb_next;

  assign rf_a_address = src_a_q;
  assign rf_b_address = src_b_q;
  assign in_ready     = in_ready_q;

  // Hazard detection and operand selection with writeback bypass
  always_comb begin
    wb_hit_a   = wb_valid && (wb_address == src_a_q);
    wb_hit_b   = wb_valid && (wb_address == src_b_q);
    haz_a      = (src_a_q != '0) && scoreboard[src_a_q] && !wb_hit_a;
    haz_b      = (src_b_q != '0) && scoreboard[src_b_q] && !wb_hit_b;
    hazard     = haz_a || haz_b;
    fetch_done = (state == FETCH) && !hazard;
    if (src_a_q == '0) begin
      opnd_a = '0;
    end else if (wb_hit_a) begin
      opnd_a = wb_data;
    end else begin
      opnd_a = rf_a_data;
    end
    if (src_b_q == '0) begin
      opnd_b = '0;
    end else if (wb_hit_b) begin
      opnd_b = wb_data;
    end else begin
      opnd_b = rf_b_data;
    end
  end

  // Scoreboard next value: writeback clears, issue sets, set wins
  always_comb begin
    sb_clr = '0;
    sb_set = '0;
    if (wb_valid && (wb_address != '0)) begin
      sb_clr[wb_address] = 1'b1;
    end
    if (fetch_done && dst_en_q && (dst_q != '0)) begin
      sb_set[dst_q] = 1'b1;
    end
    sb_next    = (scoreboard & ~sb_clr) | sb_set;
    sb_next[0] = 1'b0;
  end

  // Pending-write scoreboard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scoreboard <= '0;
    end else begin
      scoreboard <= sb_next;
    end
  end

  // Issue FSM with registered handshake and operand outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready_q <= 1'b1;
      src_a_q    <= '0;
      src_b_q    <= '0;
      dst_q      <= '0;
      dst_en_q   <= 1'b0;
      out_valid  <= 1'b0;
      out_a      <= '0;
      out_b      <= '0;
      out_dst    <= '0;
      out_dst_en <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            src_a_q    <= in_src_a;
            src_b_q    <= in_src_b;
            dst_q      <= in_dst;
            dst_en_q   <= in_dst_en;
            in_ready_q <= 1'b0;
            state      <= FETCH;
          end
        end
        FETCH: begin
          if (hazard) begin
            if (stall_cnt != 8'hFF) begin
              stall_cnt <= stall_cnt + 8'd1;
            end
          end else begin
            out_a      <= opnd_a;
            out_b      <= opnd_b;
            out_dst    <= dst_q;
            out_dst_en <= dst_en_q;
            out_valid  <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            in_ready_q <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b1;
          out_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Bench for regfile_operand_fetch: directed literal checks plus
// randomized traffic compared every cycle against a behavioural model.
module tb_regfile_operand_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_src_a;
  logic [2:0] in_src_b;
  logic [2:0] in_dst;
  logic       in_dst_en;
  logic [2:0] rf_a_address;
  logic [2:0] rf_b_address;
  logic [7:0] rf_a_data;
  logic [7:0] rf_b_data;
  logic       wb_valid;
  logic [2:0] wb_address;
  logic [7:0] wb_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_a;
  logic [7:0] out_b;
  logic [2:0] out_dst;
  logic       out_dst_en;
  logic [7:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  regfile_operand_fetch #(.WIDTH(8), .AW(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_src_a(in_src_a),
    .in_src_b(in_src_b),
    .in_dst(in_dst),
    .in_dst_en(in_dst_en),
    .rf_a_address(rf_a_address),
    .rf_b_address(rf_b_address),
    .rf_a_data(rf_a_data),
    .rf_b_data(rf_b_data),
    .wb_valid(wb_valid),
    .wb_address(wb_address),
    .wb_data(wb_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_a(out_a),
    .out_b(out_b),
    .out_dst(out_dst),
    .out_dst_en(out_dst_en),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Register file: written by writeback, register 0 returns junk
  logic [7:0] regs [8];

  always @(posedge clk) begin
    if (wb_valid && wb_address != 3'd0) regs[wb_address] <= wb_data;
  end

  assign rf_a_data = (rf_a_address == 3'd0) ? 8'hFF : regs[rf_a_address];
  assign rf_b_data = (rf_b_address == 3'd0) ? 8'hFF : regs[rf_b_address];

  // Behavioural model: one instruction in flight, a set of pending regs
  logic       m_busy, m_done;
  logic [2:0] m_sa, m_sb, m_dst;
  logic       m_den;
  logic [7:0] m_pend;
  logic [7:0] m_a, m_b;
  logic [2:0] m_odst;
  logic       m_oden;
  logic [7:0] m_stall;

  logic       n_busy, n_done;
  logic [2:0] n_sa, n_sb, n_dst;
  logic       n_den;
  logic [7:0] n_pend;
  logic [7:0] n_a, n_b;
  logic [2:0] n_odst;
  logic       n_oden;
  logic [7:0] n_stall;

  function automatic logic blocked(input logic [2:0] s, input logic [7:0] pend,
                                   input logic wv, input logic [2:0] wa);
    return (s != 3'd0) && pend[s] && !(wv && wa == s);
  endfunction

  function automatic logic [7:0] operand(input logic [2:0] s, input logic wv,
                                         input logic [2:0] wa, input logic [7:0] wd,
                                         input logic [7:0] rv);
    if (s == 3'd0) return 8'h00;
    if (wv && wa == s) return wd;
    return rv;
  endfunction

  always_comb begin
    n_busy  = m_busy;
    n_done  = m_done;
    n_sa    = m_sa;
    n_sb    = m_sb;
    n_dst   = m_dst;
    n_den   = m_den;
    n_pend  = m_pend;
    n_a     = m_a;
    n_b     = m_b;
    n_odst  = m_odst;
    n_oden  = m_oden;
    n_stall = m_stall;
    if (wb_valid && wb_address != 3'd0) n_pend[wb_address] = 1'b0;
    if (!m_busy) begin
      if (in_valid) begin
        n_busy = 1'b1;
        n_sa   = in_src_a;
        n_sb   = in_src_b;
        n_dst  = in_dst;
        n_den  = in_dst_en;
      end
    end else if (!m_done) begin
      if (blocked(m_sa, m_pend, wb_valid, wb_address) ||
          blocked(m_sb, m_pend, wb_valid, wb_address)) begin
        n_stall = (m_stall == 8'hFF) ? 8'hFF : m_stall + 8'd1;
      end else begin
        n_done = 1'b1;
        n_a    = operand(m_sa, wb_valid, wb_address, wb_data, regs[m_sa]);
        n_b    = operand(m_sb, wb_valid, wb_address, wb_data, regs[m_sb]);
        n_odst = m_dst;
        n_oden = m_den;
        if (m_den && m_dst != 3'd0) n_pend[m_dst] = 1'b1;
      end
    end else if (out_ready) begin
      n_busy = 1'b0;
      n_done = 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_sa    <= 3'd0;
      m_sb    <= 3'd0;
      m_dst   <= 3'd0;
      m_den   <= 1'b0;
      m_pend  <= 8'h00;
      m_a     <= 8'h00;
      m_b     <= 8'h00;
      m_odst  <= 3'd0;
      m_oden  <= 1'b0;
      m_stall <= 8'h00;
    end else begin
      m_busy  <= n_busy;
      m_done  <= n_done;
      m_sa    <= n_sa;
      m_sb    <= n_sb;
      m_dst   <= n_dst;
      m_den   <= n_den;
      m_pend  <= n_pend;
      m_a     <= n_a;
      m_b     <= n_b;
      m_odst  <= n_odst;
      m_oden  <= n_oden;
      m_stall <= n_stall;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    check("in_ready", in_ready, !m_busy);
    check("out_valid", out_valid, m_done);
    check("out_a", out_a, m_a);
    check("out_b", out_b, m_b);
    check("out_dst", out_dst, m_odst);
    check("out_dst_en", out_dst_en, m_oden);
    check("stall_cnt", stall_cnt, m_stall);
    check("rf_a_address", rf_a_address, m_sa);
    check("rf_b_address", rf_b_address, m_sb);
  end

  task automatic issue(input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] d, input logic en);
    in_valid  = 1'b1;
    in_src_a  = a;
    in_src_b  = b;
    in_dst    = d;
    in_dst_en = en;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_src_a   = 3'd0;
    in_src_b   = 3'd0;
    in_dst     = 3'd0;
    in_dst_en  = 1'b0;
    wb_valid   = 1'b0;
    wb_address = 3'd0;
    wb_data    = 8'h00;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_stall", stall_cnt, 8'd0);
    check("rst_rf_a", rf_a_address, 3'd0);
    rst_n = 1'b1;

    for (int i = 1; i < 8; i++) begin
      wb_valid   = 1'b1;
      wb_address = 3'(i);
      wb_data    = (i == 1) ? 8'h11 : (i == 2) ? 8'h22 : 8'(8'h30 + i);
      @(negedge clk);
    end
    wb_valid  = 1'b0;
    out_ready = 1'b1;

    issue(3'd1, 3'd2, 3'd3, 1'b1);
    check("t1_fetch_valid", out_valid, 1'b0);
    check("t1_fetch_ready", in_ready, 1'b0);
    @(negedge clk);
    check("t1_valid", out_valid, 1'b1);
    check("t1_a", out_a, 8'h11);
    check("t1_b", out_b, 8'h22);
    check("t1_dst", out_dst, 3'd3);
    check("t1_dst_en", out_dst_en, 1'b1);
    @(negedge clk);
    check("t1_idle", in_ready, 1'b1);

    issue(3'd3, 3'd0, 3'd5, 1'b0);
    repeat (4) @(negedge clk);
    check("t2_stall", stall_cnt, 8'd4);
    check("t2_valid", out_valid, 1'b0);
    check("t2_ready", in_ready, 1'b0);
    wb_valid   = 1'b1;
    wb_address = 3'd3;
    wb_data    = 8'h5A;
    @(negedge clk);
    wb_valid = 1'b0;
    check("t2_bypass_valid", out_valid, 1'b1);
    check("t2_bypass_a", out_a, 8'h5A);
    check("t2_b_zero", out_b, 8'h00);
    @(negedge clk);

    issue(3'd0, 3'd0, 3'd0, 1'b1);
    @(negedge clk);
    check("t3_a_zero", out_a, 8'h00);
    check("t3_b_zero", out_b, 8'h00);
    @(negedge clk);

    issue(3'd3, 3'd0, 3'd4, 1'b1);
    wb_valid   = 1'b1;
    wb_address = 3'd4;
    wb_data    = 8'h77;
    @(negedge clk);
    wb_valid = 1'b0;
    check("t4_no_stall", out_valid, 1'b1);
    check("t4_a", out_a, 8'h5A);
    check("t4_stall", stall_cnt, 8'd4);
    @(negedge clk);

    issue(3'd4, 3'd4, 3'd1, 1'b0);
    repeat (2) @(negedge clk);
    check("t4_setwins_valid", out_valid, 1'b0);
    check("t4_setwins_stall", stall_cnt, 8'd6);

    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 1'b0);
    check("t5_rst_stall", stall_cnt, 8'd0);
    check("t5_rst_ready", in_ready, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("t5_after_ready", in_ready, 1'b1);

    out_ready = 1'b0;
    issue(3'd4, 3'd1, 3'd6, 1'b1);
    @(negedge clk);
    check("t6_valid", out_valid, 1'b1);
    check("t6_a", out_a, 8'h77);
    check("t6_b", out_b, 8'h11);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t6_hold_a", out_a, 8'h77);
      check("t6_hold_b", out_b, 8'h11);
      check("t6_hold_dst", out_dst, 3'd6);
      check("t6_hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t6_release_ready", in_ready, 1'b1);
    check("t6_release_valid", out_valid, 1'b0);

    repeat (3000) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_src_a   = 3'($urandom_range(0, 7));
      in_src_b   = 3'($urandom_range(0, 7));
      in_dst     = 3'($urandom_range(0, 7));
      in_dst_en  = ($urandom_range(0, 3) != 0);
      wb_valid   = ($urandom_range(0, 9) < 3);
      wb_address = 3'($urandom_range(0, 7));
      wb_data    = 8'($urandom_range(0, 255));
      out_ready  = ($urandom_range(0, 9) < 6);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wb_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
